// File: rtl/fir_pkg.sv
// Shared constants and width helpers for the multichannel FIR tap line.
package fir_pkg;

  localparam int DATA_W_DEF   = 16;
  localparam int TAPS_DEF     = 15;
  localparam int CHANNELS_DEF = 2;

  // Pre-add of two DATA_W samples needs one extra bit to never overflow.
  localparam int PRESUM_EXT = 1;

  function automatic int chan_width(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

  function automatic int tap_lsb(input int k, input int data_w);
    return k * data_w;
  endfunction

  function automatic int presum_el_w(input int data_w);
    return data_w + PRESUM_EXT;
  endfunction

  function automatic int presum_elems(input int taps);
    return (taps + 1) / 2;
  endfunction

endpackage

// File: rtl/fir_tap_line_if.sv
// Sample-in / tap-vector-out handshake bundle of fir_tap_line.
// FIR_TAP_SYM_EN adds the symmetric pre-add output out_presum.
interface fir_tap_line_if #(
  parameter int DATA_W   = 16,
  parameter int TAPS     = 15,
  parameter int CHANNELS = 2
);
  localparam int CHAN_W = fir_pkg::chan_width(CHANNELS);

  logic                     in_valid;
  logic                     in_ready;
  logic [DATA_W-1:0]        in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_W*TAPS-1:0]   out_taps;
  logic [CHAN_W-1:0]        out_chan;
  logic                     out_primed;
`ifdef FIR_TAP_SYM_EN
  localparam int PRESUM_W = fir_pkg::presum_el_w(DATA_W) * fir_pkg::presum_elems(TAPS);
  logic [PRESUM_W-1:0]      out_presum;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_taps, out_chan, out_primed, out_presum
  );
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_taps, out_chan, out_primed, out_presum
  );
`else
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_taps, out_chan, out_primed
  );
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_taps, out_chan, out_primed
  );
`endif

endinterface

// File: rtl/fir_tap_chan.sv
// One channel's TAPS-deep sample history with a saturating fill counter.
// Exposes the post-shift line and post-increment primed flag for the output stage.
module fir_tap_chan
  import fir_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int TAPS   = TAPS_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     shift_en,
  input  logic signed [DATA_W-1:0] din,
  output logic [DATA_W*TAPS-1:0]   taps_nxt,
  output logic                     primed_nxt
);

  localparam int LINE_W = DATA_W * TAPS;
  localparam int FILL_W = $clog2(TAPS + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(TAPS);
  localparam logic [FILL_W-1:0] FILL_PRE = FILL_W'(TAPS - 1);

  logic [LINE_W-1:0] line_q, line_d;
  logic [FILL_W-1:0] fill_q, fill_d;

  // Tap 0 sits in the low bits, so a shift moves everything up one slot.
  assign taps_nxt   = {line_q[LINE_W-DATA_W-1:0], din};
  assign primed_nxt = (fill_q >= FILL_PRE);

  always_comb begin
    line_d = line_q;
    fill_d = fill_q;
    if (clear) begin
      line_d = '0;
      fill_d = '0;
    end else if (shift_en) begin
      line_d = taps_nxt;
      if (fill_q != FILL_MAX) fill_d = fill_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_q <= '0;
      fill_q <= '0;
    end else begin
      line_q <= line_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/fir_tap_line.sv
// CHANNELS interleaved FIR delay lines on one round-robin stream, one-cycle output register.
// Optional macro FIR_TAP_SYM_EN adds registered symmetric pre-adds (out_presum).
module fir_tap_line
  import fir_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int TAPS     = TAPS_DEF,
  parameter int CHANNELS = CHANNELS_DEF
) (
  input logic           clk,
  input logic           reset,
  input logic           clear,
  fir_tap_line_if.slave bus
);

  localparam int CHAN_W = chan_width(CHANNELS);
  localparam int LINE_W = DATA_W * TAPS;

  logic                accept;
  logic                in_ready;
  logic [CHAN_W-1:0]   ch_ptr_q, ch_ptr_d;
  logic [CHANNELS-1:0] shift_en;
  logic [CHANNELS-1:0] primed_nxt;
  logic [LINE_W-1:0]   taps_nxt [CHANNELS];
  logic [LINE_W-1:0]   sel_taps;
  logic                sel_primed;

  logic                out_valid_q, out_valid_d;
  logic [LINE_W-1:0]   out_taps_q, out_taps_d;
  logic [CHAN_W-1:0]   out_chan_q, out_chan_d;
  logic                out_primed_q, out_primed_d;

  // Single output stage without skid: ready passes straight through.
  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready && !clear;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    assign shift_en[c] = accept && (ch_ptr_q == CHAN_W'(c));

    fir_tap_chan #(
      .DATA_W (DATA_W),
      .TAPS   (TAPS)
    ) u_chan (
      .clk        (clk),
      .reset      (reset),
      .clear      (clear),
      .shift_en   (shift_en[c]),
      .din        (bus.in_data),
      .taps_nxt   (taps_nxt[c]),
      .primed_nxt (primed_nxt[c])
    );
  end

  always_comb begin
    sel_taps   = taps_nxt[0];
    sel_primed = primed_nxt[0];
    for (int c = 1; c < CHANNELS; c++) begin
      if (ch_ptr_q == CHAN_W'(c)) begin
        sel_taps   = taps_nxt[c];
        sel_primed = primed_nxt[c];
      end
    end
  end

  always_comb begin
    ch_ptr_d     = ch_ptr_q;
    out_valid_d  = out_valid_q;
    out_taps_d   = out_taps_q;
    out_chan_d   = out_chan_q;
    out_primed_d = out_primed_q;
    if (clear) begin
      ch_ptr_d     = '0;
      out_valid_d  = 1'b0;
      out_taps_d   = '0;
      out_chan_d   = '0;
      out_primed_d = 1'b0;
    end else if (accept) begin
      ch_ptr_d     = (ch_ptr_q == CHAN_W'(CHANNELS - 1)) ? '0 : ch_ptr_q + 1'b1;
      out_valid_d  = 1'b1;
      out_taps_d   = sel_taps;
      out_chan_d   = ch_ptr_q;
      out_primed_d = sel_primed;
    end else if (bus.out_ready) begin
      out_valid_d  = 1'b0;
    end
  end

  // ---- output register stage ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ch_ptr_q     <= '0;
      out_valid_q  <= 1'b0;
      out_taps_q   <= '0;
      out_chan_q   <= '0;
      out_primed_q <= 1'b0;
    end else begin
      ch_ptr_q     <= ch_ptr_d;
      out_valid_q  <= out_valid_d;
      out_taps_q   <= out_taps_d;
      out_chan_q   <= out_chan_d;
      out_primed_q <= out_primed_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_taps   = out_taps_q;
  assign bus.out_chan   = out_chan_q;
  assign bus.out_primed = out_primed_q;

`ifdef FIR_TAP_SYM_EN
  localparam int PS_EW = presum_el_w(DATA_W);
  localparam int PS_N  = presum_elems(TAPS);
  localparam int PS_W  = PS_EW * PS_N;

  logic [PS_W-1:0] presum_nxt;
  logic [PS_W-1:0] out_presum_q, out_presum_d;

  function automatic logic signed [DATA_W:0] sext(input logic signed [DATA_W-1:0] a);
    return {a[DATA_W-1], a};
  endfunction

  function automatic logic signed [DATA_W:0] sym_add(input logic signed [DATA_W-1:0] a,
                                                     input logic signed [DATA_W-1:0] b);
    return sext(a) + sext(b);
  endfunction

  always_comb begin
    presum_nxt = '0;
    for (int j = 0; j < TAPS / 2; j++) begin
      presum_nxt[j*PS_EW +: PS_EW] = sym_add(sel_taps[tap_lsb(j, DATA_W) +: DATA_W],
                                             sel_taps[tap_lsb(TAPS-1-j, DATA_W) +: DATA_W]);
    end
    // Odd-length filters have an unpaired centre tap.
    if (TAPS % 2 == 1) begin
      presum_nxt[(PS_N-1)*PS_EW +: PS_EW] = sext(sel_taps[tap_lsb((TAPS-1)/2, DATA_W) +: DATA_W]);
    end
  end

  always_comb begin
    out_presum_d = out_presum_q;
    if (clear) out_presum_d = '0;
    else if (accept) out_presum_d = presum_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) out_presum_q <= '0;
    else out_presum_q <= out_presum_d;
  end

  assign bus.out_presum = out_presum_q;
`endif

endmodule

// File: tb/tb_fir_tap_line.sv
// Directed bench for fir_tap_line: a two-channel and a single-channel instance side by side.
module tb_fir_tap_line;

  localparam int DW = 16;
  localparam int TP = 15;
  localparam int LW = DW * TP;

  logic clk = 1'b0;
  logic reset;
  logic clear2;
  logic clear1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fir_tap_line_if #(.DATA_W(DW), .TAPS(TP), .CHANNELS(2)) bus2 ();
  fir_tap_line_if #(.DATA_W(DW), .TAPS(TP), .CHANNELS(1)) bus1 ();

  fir_tap_line #(.DATA_W(DW), .TAPS(TP), .CHANNELS(2)) u_dut2 (
    .clk   (clk),
    .reset (reset),
    .clear (clear2),
    .bus   (bus2)
  );

  fir_tap_line #(.DATA_W(DW), .TAPS(TP), .CHANNELS(1)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .clear (clear1),
    .bus   (bus1)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    clear2 = 1'b0; clear1 = 1'b0;
    bus2.in_valid = 1'b0; bus2.in_data = '0; bus2.out_ready = 1'b1;
    bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.out_ready = 1'b1;
    tick(); tick();
    checks++; if (bus2.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid2 got %b exp 0", bus2.out_valid); end
    checks++; if (bus2.out_taps !== '0) begin errors++; $display("FAIL reset_taps2 got %h exp 0", bus2.out_taps); end
    checks++; if (bus2.out_chan !== 1'b0) begin errors++; $display("FAIL reset_chan2 got %0d exp 0", bus2.out_chan); end
    checks++; if (bus2.out_primed !== 1'b0) begin errors++; $display("FAIL reset_primed2 got %b exp 0", bus2.out_primed); end
    checks++; if (bus2.in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready2 got %b exp 1", bus2.in_ready); end
    checks++; if (bus1.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid1 got %b exp 0", bus1.out_valid); end
    checks++; if (bus1.out_taps !== '0) begin errors++; $display("FAIL reset_taps1 got %h exp 0", bus1.out_taps); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_round_robin;
    logic [LW-1:0] exp_taps [4];
    exp_taps[0] = LW'(64'h0001);
    exp_taps[1] = LW'(64'h0002);
    exp_taps[2] = LW'(64'h0001_0003);
    exp_taps[3] = LW'(64'h0002_0004);
    bus2.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus2.in_valid = 1'b1;
      bus2.in_data  = 16'(i + 1);
      tick();
      checks++; if (bus2.out_valid !== 1'b1) begin errors++; $display("FAIL rr_valid[%0d] got %b exp 1", i, bus2.out_valid); end
      checks++; if (bus2.out_chan !== 1'(i % 2)) begin errors++; $display("FAIL rr_chan[%0d] got %0d exp %0d", i, bus2.out_chan, i % 2); end
      checks++; if (bus2.out_taps !== exp_taps[i]) begin errors++; $display("FAIL rr_taps[%0d] got %h exp %h", i, bus2.out_taps, exp_taps[i]); end
      checks++; if (bus2.out_primed !== 1'b0) begin errors++; $display("FAIL rr_primed[%0d] got %b exp 0", i, bus2.out_primed); end
    end
    bus2.in_valid = 1'b0;
    tick();
    checks++; if (bus2.out_valid !== 1'b0) begin errors++; $display("FAIL rr_drain got %b exp 0", bus2.out_valid); end
  endtask

  task automatic test_primed;
    bus1.out_ready = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      bus1.in_valid = 1'b1;
      bus1.in_data  = 16'(n);
      tick();
      checks++; if (bus1.out_primed !== (n >= 15)) begin errors++; $display("FAIL primed[%0d] got %b exp %b", n, bus1.out_primed, (n >= 15)); end
      checks++; if (bus1.out_chan !== 1'b0) begin errors++; $display("FAIL primed_chan[%0d] got %0d exp 0", n, bus1.out_chan); end
      if (n == 15) begin
        checks++; if (bus1.out_taps[14*DW +: DW] !== 16'd1) begin errors++; $display("FAIL p15_tap14 got %h exp 0001", bus1.out_taps[14*DW +: DW]); end
      end
      if (n == 16) begin
        checks++; if (bus1.out_taps[0 +: DW] !== 16'd16) begin errors++; $display("FAIL p16_tap0 got %h exp 0010", bus1.out_taps[0 +: DW]); end
        checks++; if (bus1.out_taps[14*DW +: DW] !== 16'd2) begin errors++; $display("FAIL p16_tap14 got %h exp 0002", bus1.out_taps[14*DW +: DW]); end
      end
    end
    bus1.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_hold;
    logic [LW-1:0] exp_a;
    logic [LW-1:0] exp_b;
    exp_a = LW'(64'h0001_0003_0005);
    exp_b = LW'(64'h0002_0004_0006);
    bus2.out_ready = 1'b0;
    bus2.in_valid  = 1'b1;
    bus2.in_data   = 16'h0005;
    #1;
    checks++; if (bus2.in_ready !== 1'b1) begin errors++; $display("FAIL hold_idle_ready got %b exp 1", bus2.in_ready); end
    tick();
    bus2.in_data = 16'h0006;
    for (int k = 0; k < 5; k++) begin
      checks++; if (bus2.in_ready !== 1'b0) begin errors++; $display("FAIL hold_ready[%0d] got %b exp 0", k, bus2.in_ready); end
      checks++; if (bus2.out_valid !== 1'b1) begin errors++; $display("FAIL hold_valid[%0d] got %b exp 1", k, bus2.out_valid); end
      checks++; if (bus2.out_taps !== exp_a) begin errors++; $display("FAIL hold_taps[%0d] got %h exp %h", k, bus2.out_taps, exp_a); end
      checks++; if (bus2.out_chan !== 1'b0) begin errors++; $display("FAIL hold_chan[%0d] got %0d exp 0", k, bus2.out_chan); end
      tick();
    end
    bus2.out_ready = 1'b1;
    #1;
    checks++; if (bus2.in_ready !== 1'b1) begin errors++; $display("FAIL release_ready got %b exp 1", bus2.in_ready); end
    tick();
    checks++; if (bus2.out_valid !== 1'b1) begin errors++; $display("FAIL release_valid got %b exp 1", bus2.out_valid); end
    checks++; if (bus2.out_chan !== 1'b1) begin errors++; $display("FAIL release_chan got %0d exp 1", bus2.out_chan); end
    checks++; if (bus2.out_taps !== exp_b) begin errors++; $display("FAIL release_taps got %h exp %h", bus2.out_taps, exp_b); end
    bus2.in_valid = 1'b0;
    tick();
    checks++; if (bus2.out_valid !== 1'b0) begin errors++; $display("FAIL release_drain got %b exp 0", bus2.out_valid); end
  endtask

  task automatic test_clear;
    bus2.out_ready = 1'b1;
    bus2.in_valid  = 1'b1;
    bus2.in_data   = 16'h0007;
    tick();
    checks++; if (bus2.out_taps !== LW'(64'h0001_0003_0005_0007)) begin errors++; $display("FAIL pre_clear_taps got %h", bus2.out_taps); end
    clear2 = 1'b1;
    bus2.in_data = 16'h0008;
    tick();
    clear2 = 1'b0;
    bus2.in_valid = 1'b0;
    checks++; if (bus2.out_valid !== 1'b0) begin errors++; $display("FAIL clear_valid got %b exp 0", bus2.out_valid); end
    checks++; if (bus2.out_taps !== '0) begin errors++; $display("FAIL clear_taps got %h exp 0", bus2.out_taps); end
    checks++; if (bus2.out_chan !== 1'b0) begin errors++; $display("FAIL clear_chan got %0d exp 0", bus2.out_chan); end
    checks++; if (bus2.out_primed !== 1'b0) begin errors++; $display("FAIL clear_primed got %b exp 0", bus2.out_primed); end
    bus2.in_valid = 1'b1;
    bus2.in_data  = 16'h0009;
    tick();
    checks++; if (bus2.out_chan !== 1'b0) begin errors++; $display("FAIL post_clear_chan got %0d exp 0", bus2.out_chan); end
    checks++; if (bus2.out_primed !== 1'b0) begin errors++; $display("FAIL post_clear_primed got %b exp 0", bus2.out_primed); end
    checks++; if (bus2.out_taps !== LW'(64'h0009)) begin errors++; $display("FAIL post_clear_taps got %h exp 9", bus2.out_taps); end
    bus2.in_data = 16'h000A;
    tick();
    bus2.in_valid = 1'b0;
    checks++; if (bus2.out_chan !== 1'b1) begin errors++; $display("FAIL post_clear_chan1 got %0d exp 1", bus2.out_chan); end
    checks++; if (bus2.out_taps !== LW'(64'h000A)) begin errors++; $display("FAIL post_clear_taps1 got %h exp a", bus2.out_taps); end
  endtask

  task automatic test_async_reset;
    // Outputs of dut2 are valid with chan 1 here; dut1 still holds its last taps.
    #2;
    reset = 1'b1;
    #1;
    checks++; if (bus2.out_valid !== 1'b0) begin errors++; $display("FAIL areset_valid got %b exp 0", bus2.out_valid); end
    checks++; if (bus2.out_taps !== '0) begin errors++; $display("FAIL areset_taps got %h exp 0", bus2.out_taps); end
    checks++; if (bus2.out_chan !== 1'b0) begin errors++; $display("FAIL areset_chan got %0d exp 0", bus2.out_chan); end
    checks++; if (bus1.out_taps !== '0) begin errors++; $display("FAIL areset_taps1 got %h exp 0", bus1.out_taps); end
    #1;
    reset = 1'b0;
    bus2.in_valid = 1'b1;
    bus2.in_data  = 16'h000B;
    tick();
    bus2.in_valid = 1'b0;
    checks++; if (bus2.out_chan !== 1'b0) begin errors++; $display("FAIL post_areset_chan got %0d exp 0", bus2.out_chan); end
    checks++; if (bus2.out_taps !== LW'(64'h000B)) begin errors++; $display("FAIL post_areset_taps got %h exp b", bus2.out_taps); end
    checks++; if (bus2.out_primed !== 1'b0) begin errors++; $display("FAIL post_areset_primed got %b exp 0", bus2.out_primed); end
    tick();
  endtask

`ifdef FIR_TAP_SYM_EN
  task automatic test_presum;
    bus1.out_ready = 1'b1;
    for (int n = 1; n <= 15; n++) begin
      bus1.in_valid = 1'b1;
      bus1.in_data  = (n == 1 || n == 15) ? 16'h7FFF : (n == 8) ? 16'h8001 : 16'h0000;
      tick();
    end
    bus1.in_valid = 1'b0;
    checks++; if (bus1.out_presum[0 +: 17] !== 17'h0FFFE) begin errors++; $display("FAIL presum0 got %h exp 0fffe", bus1.out_presum[0 +: 17]); end
    checks++; if (bus1.out_presum[17 +: 17] !== 17'h00000) begin errors++; $display("FAIL presum1 got %h exp 0", bus1.out_presum[17 +: 17]); end
    checks++; if (bus1.out_presum[7*17 +: 17] !== 17'h18001) begin errors++; $display("FAIL presum_mid got %h exp 18001", bus1.out_presum[7*17 +: 17]); end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_primed();
    test_hold();
    test_clear();
    test_async_reset();
`ifdef FIR_TAP_SYM_EN
    test_presum();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_tap_line.md
Name: fir_tap_line

Overview:
- Parametrised successor to the single-channel FIR delay-line shifter.
- Holds CHANNELS independent TAPS-deep sample histories, interleaved round-robin on one input stream.
- Emits the full tap vector of the channel just updated, with valid/ready handshakes on both sides.
- Sits between the sample source and the FIR MAC array. Multichannel filters share one MAC datapath.

Parameters:
- DATA_W, 16, sample width in bits (signed two's complement).
- TAPS, 15, delay-line depth per channel; TAPS >= 2.
- CHANNELS, 2, number of interleaved channels; CHANNELS >= 1.
- CHAN_W, (CHANNELS>1 ? clog2(CHANNELS) : 1), channel index width; derived, not overridden.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous flush of all histories and state.
- in_valid  in  1  in_data carries a sample.
- in_ready  out  1  block accepts a sample this cycle.
- in_data  in  DATA_W  sample for the current channel (round-robin order).
- out_valid  out  1  out_taps/out_chan/out_primed are valid.
- out_ready  in  1  consumer accepts the output.
- out_taps  out  DATA_W*TAPS  tap k at [k*DATA_W +: DATA_W]; tap 0 is the newest sample.
- out_chan  out  CHAN_W  channel of out_taps.
- out_primed  out  1  the channel has received >= TAPS samples since reset/clear.

Behaviour:
- Reset (async) and clear (sync) set every output and state register to 0:
  - all tap registers and per-channel fill counters,
  - channel pointer ch_ptr,
  - out_valid, out_taps, out_chan, out_primed.
- Both are required to work mid-stream. clear has priority over accept in the same cycle; a sample presented with clear is dropped.
- Accept condition: in_valid && in_ready.
- in_ready = !out_valid || out_ready. This is a single output stage with no skid buffer; in_ready is combinational from out_ready.
- On accept, for channel c = ch_ptr:
  - line[c] tap0 <= in_data; tap k <= tap k-1 for k = 1..TAPS-1; the oldest sample is discarded.
  - fill[c] increments and saturates at TAPS.
  - ch_ptr wraps CHANNELS-1 -> 0.
  - Other channels are untouched.
- Latency is 1 cycle. On the edge after an accept:
  - out_taps = post-shift line[c],
  - out_chan = c,
  - out_primed = (post-increment fill[c] == TAPS),
  - out_valid = 1.
- Output hold: while out_valid && !out_ready, all out_* signals are stable and no new sample is accepted.
- out_valid clears on a handshake cycle with no new accept. Back-to-back accept plus handshake gives continuous out_valid with fresh data every cycle.
- No wrap or overflow is possible in the data path; the shift is pure data movement with no arithmetic. The fill counter saturates, so it never wraps.
- CHANNELS=1: ch_ptr is constant 0 and out_chan is 0.

Optional Feature:
- Macro: FIR_TAP_SYM_EN.
- Defined: adds output out_presum, width (DATA_W+1)*((TAPS+1)/2), for symmetric (linear-phase) FIRs.
  - Element j = signed tap j + tap TAPS-1-j, for j < TAPS/2.
  - For odd TAPS, the middle element is tap (TAPS-1)/2 sign-extended to DATA_W+1.
  - Registered with out_taps: same latency, same hold and reset behaviour.
- Undefined: the port and its adders are absent; the rest of the block is unchanged.

Decomposition:
- Package fir_pkg:
  - DATA_W/TAPS defaults,
  - clog2-based chan_width function,
  - tap-slice index helper (k*DATA_W),
  - presum element width constant.
- One natural sub-module, fir_tap_chan: one channel's TAPS-deep shift line plus saturating fill counter, with a shift-enable and a clear input. It is instantiated CHANNELS times.
- Top level owns ch_ptr, the handshake and the output register (plus the presum adders when the macro is enabled).

Test Plan:
- Defaults, out_ready=1, feed 0x0001..0x0004 continuously -> out_chan alternates 0,1,0,1; the 3rd output (chan 0) has tap0=0x0003, tap1=0x0001, all other taps 0.
- CHANNELS=1, TAPS=15, feed 16 samples 1..16 -> out_primed first high on the 15th output; 16th output has tap0=16, tap14=2.
- out_ready held 0 for 5 cycles after one accept -> in_ready=0 throughout, outputs stable; releasing out_ready -> next sample accepted the same cycle, out_valid stays 1.
- clear asserted with in_valid=1 after 7 samples -> sample dropped; next cycle out_valid=0 and all taps 0; the next accepted sample goes to chan 0 with out_primed=0.
- Async reset pulse mid-stream, between clock edges -> all outputs 0 immediately, with no clock edge needed.
- FIR_TAP_SYM_EN, TAPS=15, line holding taps 0x7FFF (tap0) and 0x7FFF (tap14) -> presum element 0 = 0x0FFFE (17-bit, no overflow); middle element = tap7 sign-extended.
